// File: rtl/regfile_write_queue.sv
// Write side of the register file: a small FIFO of pending writes retiring one per cycle
// into the array, with two combinational read ports that forward from the youngest pending write.
module regfile_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      hold,
  input  logic [ADDR_W-1:0]         rd_addr1,
  output logic [WIDTH-1:0]          rd_data1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic [WIDTH-1:0]          rd_data2,
  output logic [(1<<ADDR_W)-1:0]    reg_we,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      empty
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [ADDR_W-1:0] q_addr_q [DEPTH];
  logic [WIDTH-1:0]  q_data_q [DEPTH];
  logic [WIDTH-1:0]  regs_q   [NumRegs];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic accept, enq, retire;

  assign wr_ready = (count_q < CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pending  = count_q;
  assign accept   = wr_valid && wr_ready;
  // Writes to r0 complete the handshake but are dropped.
  assign enq      = accept && (wr_addr != '0);
  assign retire   = !empty && !hold;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (retire) head_d = head_q + PtrW'(1);
    if (enq)    tail_d = tail_q + PtrW'(1);
    if (enq && !retire)      count_d = count_q + CntW'(1);
    else if (!enq && retire) count_d = count_q - CntW'(1);
  end

  always_comb begin
    reg_we = '0;
    if (retire) reg_we[q_addr_q[head_q]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < NumRegs; r++) regs_q[r] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (retire) regs_q[q_addr_q[head_q]] <= q_data_q[head_q];
    end
  end

  // Entry storage needs no reset: only slots counted by count_q are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr_q[tail_q] <= wr_addr;
      q_data_q[tail_q] <= wr_data;
    end
  end

  logic [ADDR_W-1:0] rd_addr_arr [2];
  logic [WIDTH-1:0]  rd_val      [2];
  logic [PtrW-1:0]   fwd_idx;

  assign rd_addr_arr[0] = rd_addr1;
  assign rd_addr_arr[1] = rd_addr2;
  assign rd_data1       = rd_val[0];
  assign rd_data2       = rd_val[1];

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_idx = '0;
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = regs_q[rd_addr_arr[p]];
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_q + PtrW'(i);
        if ((CntW'(i) < count_q) && (q_addr_q[fwd_idx] == rd_addr_arr[p])) begin
          rd_val[p] = q_data_q[fwd_idx];
        end
      end
      if (rd_addr_arr[p] == '0) rd_val[p] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: scoreboard of queued writes checked against
// reg_we on retirement, plus a reference array for read-port checks.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        reset, wr_valid, wr_ready, hold, empty;
  logic [4:0]  wr_addr, rd_addr1, rd_addr2;
  logic [31:0] wr_data, rd_data1, rd_data2, reg_we;
  logic [2:0]  pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        sb [$];
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_write_queue #(
    .DEPTH (4),
    .WIDTH (32),
    .ADDR_W(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .hold    (hold),
    .rd_addr1(rd_addr1),
    .rd_data1(rd_data1),
    .rd_addr2(rd_addr2),
    .rd_data2(rd_data2),
    .reg_we  (reg_we),
    .pending (pending),
    .empty   (empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    logic [31:0] r;
    if (a == 0) return 32'h0;
    r = mem[a];
    foreach (sb[i]) if (sb[i].a == a) r = sb[i].d;
    return r;
  endfunction

  // Check state-derived outputs just before the edge, update the model, advance one cycle.
  task automatic cyc();
    logic [31:0] ew;
    bit          ret, acc;
    #1;
    check("pending", 32'(pending), 32'(sb.size()));
    check("wr_ready", 32'(wr_ready), 32'(sb.size() < 4));
    ret = (sb.size() > 0) && !hold;
    ew  = ret ? (32'h1 << sb[0].a) : 32'h0;
    check("reg_we", reg_we, ew);
    acc = wr_valid && (sb.size() < 4) && (wr_addr != 0);
    if (reset) begin
      sb.delete();
      foreach (mem[i]) mem[i] = 32'h0;
    end else begin
      if (ret) begin
        mem[sb[0].a] = sb[0].d;
        void'(sb.pop_front());
      end
      if (acc) sb.push_back('{a: wr_addr, d: wr_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr1 = a1;
    rd_addr2 = a2;
    #1;
    check({tag, "_rd1"}, rd_data1, mread(a1));
    check({tag, "_rd2"}, rd_data2, mread(a2));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; hold = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    foreach (mem[i]) mem[i] = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_ready", 32'(wr_ready), 32'h1);
    check("rst_we", reg_we, 32'h0);

    // Single write with immediate forwarding, then retirement.
    wr(5'd5, 32'hDEADBEEF);
    rd_addr1 = 5'd5; #1;
    check("fwd_r5", rd_data1, 32'hDEADBEEF);
    check("we_r5", reg_we, 32'h0000_0020);
    cyc();
    check("drain_pending", 32'(pending), 32'h0);
    rd_addr1 = 5'd5; #1;
    check("array_r5", rd_data1, 32'hDEADBEEF);

    // Write to r0 is dropped.
    wr(5'd0, 32'hFFFFFFFF);
    #1;
    check("r0_pending", 32'(pending), 32'h0);
    check("r0_we", reg_we, 32'h0);
    rd_addr1 = 5'd0; rd_addr2 = 5'd0; #1;
    check("r0_rd1", rd_data1, 32'h0);
    check("r0_rd2", rd_data2, 32'h0);

    // Fill under hold, reject when full, then drain in order.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'(i));
    #1;
    check("full_pending", 32'(pending), 32'h4);
    check("full_ready", 32'(wr_ready), 32'h0);
    wr(5'd6, 32'h66);
    #1;
    check("full_reject", 32'(pending), 32'h4);
    rd_addr1 = 5'd3; #1;
    check("fwd_r3", rd_data1, 32'h3);
    rd_check("full", 5'd6, 5'd4);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_we", reg_we, 32'h1 << i);
      cyc();
    end
    check("drain_empty", 32'(empty), 32'h1);
    rd_check("drained", 5'd2, 5'd6);

    // Same-address writes: youngest forwarded and finally retired.
    hold = 1'b1;
    wr(5'd7, 32'hA);
    wr(5'd7, 32'hB);
    rd_addr2 = 5'd7; #1;
    check("fwd_r7", rd_data2, 32'hB);
    hold = 1'b0;
    cyc(); cyc();
    rd_addr1 = 5'd7; #1;
    check("array_r7", rd_data1, 32'hB);

    // Streaming across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'(8 + i);
      wr_data  = 32'h1000 + 32'(i * 17);
      if (i > 0) begin
        #1;
        check("stream_pending", 32'(pending), 32'h1);
        check("stream_ready", 32'(wr_ready), 32'h1);
      end
      cyc();
    end
    wr_valid = 1'b0;
    cyc();
    for (int i = 0; i < 10; i += 2) rd_check("stream", 5'(8 + i), 5'(9 + i));
    rd_addr1 = 5'd17; #1;
    check("stream_last", rd_data1, 32'h1000 + 32'(9 * 17));

    // Reset with entries pending discards them and clears the array.
    hold = 1'b1;
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd3, 32'h33);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rst2_pending", 32'(pending), 32'h0);
    check("rst2_we", reg_we, 32'h0);
    for (int r = 0; r < 32; r++) begin
      rd_addr1 = 5'(r); rd_addr2 = 5'(31 - r);
      #0.1;
      check("rst2_rd1", rd_data1, 32'h0);
      check("rst2_rd2", rd_data2, 32'h0);
    end
    @(posedge clk); #1;
    hold = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
